// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a byte stream big-endian into 512-bit blocks
// and appends the 0x80 terminator, zero fill and 64-bit bit-length.
module sha256_padder #(
    parameter int LEN_W = 32
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [0:511] blk_data,
    output logic         blk_valid,
    output logic         blk_first,
    output logic         blk_last,
    input  logic         blk_ready
);

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        EMIT      = 2'd1,
        EMIT_LAST = 2'd2
    } state_t;

    state_t             state_r,  state_s;
    logic [5:0]         pos_r,    pos_s;
    logic [LEN_W-1:0]   cnt_r,    cnt_s;
    logic [LEN_W-1:0]   cnt_inc_s;
    logic [0:511]       buf_r,    buf_s;
    logic               pend_r,   pend_s;
    logic               pend80_r, pend80_s;
    logic               arm_r,    arm_s;
    logic               first_r,  first_s;
    logic               last_r,   last_s;
    logic               ready_r,  ready_s;
    logic               valid_r,  valid_s;
    logic [8:0]         byte_idx_s;
    logic [8:0]         pad_idx_s;

    // Bit length of a byte count, wrapped to LEN_W+3 bits then zero-extended.
    function automatic logic [63:0] len_field(input logic [LEN_W-1:0] count);
        return 64'({count, 3'b000});
    endfunction

    assign cnt_inc_s  = cnt_r + LEN_W'(1);
    assign byte_idx_s = {pos_r, 3'b000};
    assign pad_idx_s  = {pos_r + 6'd1, 3'b000};

    // Next-state, buffer assembly and output-flag computation.
    always_comb begin
        state_s  = state_r;
        pos_s    = pos_r;
        cnt_s    = cnt_r;
        buf_s    = buf_r;
        pend_s   = pend_r;
        pend80_s = pend80_r;
        arm_s    = arm_r;
        first_s  = first_r;
        last_s   = last_r;
        case (state_r)
            FILL: begin
                if (in_valid) begin
                    buf_s[byte_idx_s +: 8] = in_data;
                    pos_s = pos_r + 6'd1;
                    cnt_s = cnt_inc_s;
                    if (in_last) begin
                        first_s = arm_r;
                        arm_s   = 1'b0;
                        if (pos_r <= 6'd54) begin
                            buf_s[pad_idx_s +: 8] = 8'h80;
                            buf_s[448 +: 64]      = len_field(cnt_inc_s);
                            state_s = EMIT_LAST;
                            last_s  = 1'b1;
                            pend_s  = 1'b0;
                        end else if (pos_r <= 6'd62) begin
                            buf_s[pad_idx_s +: 8] = 8'h80;
                            state_s  = EMIT;
                            last_s   = 1'b0;
                            pend_s   = 1'b1;
                            pend80_s = 1'b0;
                        end else begin
                            state_s  = EMIT;
                            last_s   = 1'b0;
                            pend_s   = 1'b1;
                            pend80_s = 1'b1;
                        end
                    end else if (pos_r == 6'd63) begin
                        first_s = arm_r;
                        arm_s   = 1'b0;
                        state_s = EMIT;
                        last_s  = 1'b0;
                        pend_s  = 1'b0;
                    end else begin
                        state_s = FILL;
                    end
                end else begin
                    state_s = FILL;
                end
            end
            EMIT: begin
                if (blk_ready) begin
                    buf_s   = '0;
                    first_s = 1'b0;
                    if (pend_r) begin
                        // The pad block carries the terminator only when the data ended on byte 63.
                        if (pend80_r) begin
                            buf_s[0 +: 8] = 8'h80;
                        end else begin
                            buf_s[0 +: 8] = 8'h00;
                        end
                        buf_s[448 +: 64] = len_field(cnt_r);
                        state_s = EMIT_LAST;
                        last_s  = 1'b1;
                        pend_s  = 1'b0;
                    end else begin
                        state_s = FILL;
                        pos_s   = 6'd0;
                        last_s  = 1'b0;
                    end
                end else begin
                    state_s = EMIT;
                end
            end
            EMIT_LAST: begin
                if (blk_ready) begin
                    state_s = FILL;
                    pos_s   = 6'd0;
                    cnt_s   = '0;
                    buf_s   = '0;
                    arm_s   = 1'b1;
                    first_s = 1'b0;
                    last_s  = 1'b0;
                    pend_s  = 1'b0;
                end else begin
                    state_s = EMIT_LAST;
                end
            end
            default: begin
                state_s = FILL;
                pos_s   = 6'd0;
                cnt_s   = '0;
                buf_s   = '0;
                arm_s   = 1'b1;
                first_s = 1'b0;
                last_s  = 1'b0;
                pend_s  = 1'b0;
            end
        endcase
        ready_s = (state_s == FILL);
        valid_s = (state_s != FILL);
    end

    // State, buffer and output registers.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_r  <= FILL;
            pos_r    <= 6'd0;
            cnt_r    <= '0;
            buf_r    <= '0;
            pend_r   <= 1'b0;
            pend80_r <= 1'b0;
            arm_r    <= 1'b1;
            first_r  <= 1'b0;
            last_r   <= 1'b0;
            ready_r  <= 1'b1;
            valid_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            pos_r    <= pos_s;
            cnt_r    <= cnt_s;
            buf_r    <= buf_s;
            pend_r   <= pend_s;
            pend80_r <= pend80_s;
            arm_r    <= arm_s;
            first_r  <= first_s;
            last_r   <= last_s;
            ready_r  <= ready_s;
            valid_r  <= valid_s;
        end
    end

    assign in_ready  = ready_r;
    assign blk_valid = valid_r;
    assign blk_first = first_r;
    assign blk_last  = last_r;
    assign blk_data  = buf_r;

endmodule

// File: tb/tb_sha256_padder.sv
// Randomised scoreboard bench for sha256_padder; expected blocks come from a
// byte-level FIPS 180-4 padding model.
module tb_sha256_padder;

    logic         CLK = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [0:511] blk_data;
    logic         blk_valid;
    logic         blk_first;
    logic         blk_last;
    logic         blk_ready = 1'b0;

    typedef struct {
        logic [0:511] d;
        logic         f;
        logic         l;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           fails = 0;
    logic         rdy_rand = 1'b0;
    logic [0:511] last_blk = '0;
    logic [0:511] abc_c;

    sha256_padder #(.LEN_W(32)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .blk_ready (blk_ready)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        fails++;
        $display("FAIL %s: bound expired, got timeout expected event", name);
    endtask

    // Reference: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
    task automatic model_push(input logic [7:0] msg[$]);
        logic [7:0]  p[$];
        logic [63:0] bits;
        exp_t        e;
        int          nblk;
        p = msg;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bits = 64'(msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bits[i*8 +: 8]);
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            e.d = '0;
            for (int k = 0; k < 64; k++) e.d[k*8 +: 8] = p[b*64 + k];
            e.f = (b == 0);
            e.l = (b == nblk - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input logic [7:0] msg[$], input logic finish_msg, input int max_gap);
        int g;
        int bound;
        for (int i = 0; i < msg.size(); i++) begin
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                in_last  = 1'($urandom_range(0, 1));
                @(posedge CLK); #1;
            end
            in_data  = msg[i];
            in_last  = finish_msg && (i == msg.size() - 1);
            in_valid = 1'b1;
            bound = 0;
            while (!in_ready && bound < 600) begin
                @(posedge CLK); #1;
                bound++;
            end
            if (!in_ready) begin
                timeout_fail("in_ready_wait");
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("drain_queue_empty", 512'(exp_q.size()), 512'd0);
    endtask

    task automatic rand_msg(output logic [7:0] msg[$], input int len);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
    endtask

    // Consumer ready driver.
    initial begin
        forever begin
            @(posedge CLK); #1;
            if (rdy_rand) blk_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard on every accepted block and checks output stability.
    initial begin
        logic         hold_v;
        logic [0:511] hold_d;
        logic         hold_f;
        logic         hold_l;
        exp_t         e;
        hold_v = 1'b0;
        hold_d = '0;
        hold_f = 1'b0;
        hold_l = 1'b0;
        forever begin
            @(negedge CLK);
            if (!reset) begin
                hold_v = 1'b0;
            end else begin
                chk("valid_ready_exclusive", 512'(blk_valid && in_ready), 512'd0);
                if (hold_v) begin
                    chk("hold_valid", 512'(blk_valid), 512'd1);
                    chk("hold_data", blk_data, hold_d);
                    chk("hold_flags", 512'({blk_first, blk_last}), 512'({hold_f, hold_l}));
                end
                hold_v = blk_valid && !blk_ready;
                hold_d = blk_data;
                hold_f = blk_first;
                hold_l = blk_last;
                if (blk_valid && blk_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_block", 512'd1, 512'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("blk_data", blk_data, e.d);
                        chk("blk_first", 512'(blk_first), 512'(e.f));
                        chk("blk_last", 512'(blk_last), 512'(e.l));
                    end
                    last_blk = blk_data;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation timeout expected completion");
        $display("%0d/%0d checks passed", checks - fails - 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] msg[$];
        logic [7:0] abc[$];
        int         n;
        abc_c = '0;
        abc_c[0:31]    = 32'h61626380;
        abc_c[448:511] = 64'h18;
        abc = '{8'h61, 8'h62, 8'h63};

        // Reset values.
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_valid", 512'(blk_valid), 512'd0);
        chk("rst_first", 512'(blk_first), 512'd0);
        chk("rst_last", 512'(blk_last), 512'd0);
        chk("rst_data", blk_data, 512'd0);
        reset = 1'b1;
        @(posedge CLK); #1;
        chk("rst_in_ready", 512'(in_ready), 512'd1);

        // "abc" under 10 cycles of backpressure.
        rdy_rand  = 1'b0;
        blk_ready = 1'b0;
        model_push(abc);
        send(abc, 1'b1, 0);
        n = 0;
        while (!blk_valid && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!blk_valid) timeout_fail("abc_valid_wait");
        for (int c = 0; c < 10; c++) begin
            chk("bp_valid", 512'(blk_valid), 512'd1);
            chk("bp_in_ready", 512'(in_ready), 512'd0);
            chk("bp_data", blk_data, abc_c);
            @(posedge CLK); #1;
        end
        chk("abc_flags", 512'({blk_first, blk_last}), 512'(2'b11));
        blk_ready = 1'b1;
        @(posedge CLK); #1;
        blk_ready = 1'b0;
        chk("post_accept_in_ready", 512'(in_ready), 512'd1);
        chk("post_accept_valid", 512'(blk_valid), 512'd0);
        chk("abc_block_const", last_blk, abc_c);
        rdy_rand = 1'b1;

        // Padding boundaries: 55, 56, 63, 64 bytes.
        msg.delete();
        for (int i = 0; i < 55; i++) msg.push_back(8'h00);
        model_push(msg); send(msg, 1'b1, 2); wait_drain();
        msg.delete();
        for (int i = 0; i < 56; i++) msg.push_back(8'hFF);
        model_push(msg); send(msg, 1'b1, 2); wait_drain();
        rand_msg(msg, 63);
        model_push(msg); send(msg, 1'b1, 1); wait_drain();
        rand_msg(msg, 64);
        model_push(msg); send(msg, 1'b1, 1); wait_drain();

        // Reset after 30 of 100 bytes, then a clean "abc".
        rand_msg(msg, 100);
        msg = msg[0:29];
        send(msg, 1'b0, 1);
        reset = 1'b0;
        #1;
        chk("midrst_valid", 512'(blk_valid), 512'd0);
        chk("midrst_first", 512'(blk_first), 512'd0);
        chk("midrst_last", 512'(blk_last), 512'd0);
        chk("midrst_data", blk_data, 512'd0);
        @(posedge CLK); #1;
        reset = 1'b1;
        @(posedge CLK); #1;
        chk("midrst_in_ready", 512'(in_ready), 512'd1);
        model_push(abc); send(abc, 1'b1, 0); wait_drain();
        chk("abc_after_reset", last_blk, abc_c);

        // Back-to-back: 130 bytes then "abc".
        rand_msg(msg, 130);
        model_push(msg);
        model_push(abc);
        send(msg, 1'b1, 0);
        send(abc, 1'b1, 0);
        wait_drain();

        // Random lengths with random gaps and backpressure.
        for (int t = 0; t < 12; t++) begin
            rand_msg(msg, int'($urandom_range(1, 200)));
            model_push(msg);
            send(msg, 1'b1, 3);
        end
        wait_drain();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
